// File: rtl/oled_pattern_gen_if.sv
// Coordinate/colour bus between the OLED scan engine (master) and the pattern source (slave).
interface oled_pattern_gen_if #(
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 8
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    mode;
  logic          freeze;
  logic [15:0]   color;
  logic          frame_start;
  logic [7:0]    frame_cnt;

  modport master (
    output x, y, mode, freeze,
    input  color, frame_start, frame_cnt
  );

  modport slave (
    input  x, y, mode, freeze,
    output color, frame_start, frame_cnt
  );
endinterface

// File: rtl/oled_pattern_gen.sv
// RGB565 pattern source for oled_video: static/scrolling checker, colour bars, gradient.
// Optional white panel border when OLED_PATTERN_BORDER_EN is defined (adds H_RES/V_RES).
module oled_pattern_gen #(
  parameter int unsigned XW        = 7,
  parameter int unsigned YW        = 8,
  parameter int unsigned TILE_LOG2 = 3,
  parameter logic [15:0] COLOR_A   = 16'h07E0,
  parameter logic [15:0] COLOR_B   = 16'hF800,
  parameter int unsigned FRAME_DIV = 4
`ifdef OLED_PATTERN_BORDER_EN
  ,
  parameter int unsigned H_RES     = 128,
  parameter int unsigned V_RES     = 160
`endif
) (
  input  logic              clk,
  input  logic              resn,
  oled_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_GRAD   = 2'd3
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [YW-1:0] offset, offset_d;
  logic [7:0]    div, div_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_start_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          fs;

  // x_q/y_q reset to all ones so the first (0,0) after reset is a frame start
  assign fs = (bus.x == '0) && (bus.y == '0) && !((x_q == '0) && (y_q == '0));

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      mode_q        <= MODE_STATIC;
      offset        <= '0;
      div           <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      x_q           <= '1;
      y_q           <= '1;
    end else begin
      mode_q        <= mode_d;
      offset        <= offset_d;
      div           <= div_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= fs;
      x_q           <= bus.x;
      y_q           <= bus.y;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    offset_d    = offset;
    div_d       = div;
    frame_cnt_d = frame_cnt_q;
    if (fs) begin
      mode_d      = mode_t'(bus.mode);
      frame_cnt_d = frame_cnt_q + 8'd1;
      // scroll step uses the mode in force for the frame just ended
      if (mode_q == MODE_SCROLL && !bus.freeze) begin
        if (div == 8'(FRAME_DIV - 1)) begin
          div_d    = '0;
          offset_d = offset + 1'b1;
        end else begin
          div_d = div + 8'd1;
        end
      end
    end
  end

  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [2:0]    bar;
  logic [15:0]   pat;

  always_comb begin
    xs  = bus.x + offset[XW-1:0];
    ys  = bus.y + offset;
    bar = bus.x[XW-1 -: 3];
    pat = '0;
    case (mode_q)
      MODE_STATIC: pat = (bus.x[TILE_LOG2] ^ bus.y[TILE_LOG2]) ? COLOR_A : COLOR_B;
      MODE_SCROLL: pat = (xs[TILE_LOG2] ^ ys[TILE_LOG2]) ? COLOR_A : COLOR_B;
      MODE_BARS: begin
        case (bar)
          3'd0:    pat = 16'hFFFF;
          3'd1:    pat = 16'hFFE0;
          3'd2:    pat = 16'h07FF;
          3'd3:    pat = 16'h07E0;
          3'd4:    pat = 16'hF81F;
          3'd5:    pat = 16'hF800;
          3'd6:    pat = 16'h001F;
          default: pat = 16'h0000;
        endcase
      end
      MODE_GRAD: pat = {bus.x[XW-1 -: 5], frame_cnt_q[7:2], bus.y[YW-1 -: 5]};
      default:   pat = '0;
    endcase
  end

`ifdef OLED_PATTERN_BORDER_EN
  logic border;
  assign border = (bus.x == '0) || (bus.x == XW'(H_RES - 1)) ||
                  (bus.y == '0) || (bus.y == YW'(V_RES - 1));
  assign bus.color = border ? 16'hFFFF : pat;
`else
  assign bus.color = pat;
`endif

  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_oled_pattern_gen.sv
// Directed self-checking bench for oled_pattern_gen (default parameters).
module tb_oled_pattern_gen;

  logic clk;
  logic resn;
  int   n_checks;
  int   n_fails;

  oled_pattern_gen_if #(.XW(7), .YW(8)) bus ();

  oled_pattern_gen #(
    .XW(7), .YW(8), .TILE_LOG2(3),
    .COLOR_A(16'h07E0), .COLOR_B(16'hF800), .FRAME_DIV(4)
  ) dut (
    .clk  (clk),
    .resn (resn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_xy(input int unsigned xv, input int unsigned yv);
    bus.x = 7'(xv);
    bus.y = 8'(yv);
    #1;
  endtask

  // one short frame: (0,0) then a non-origin pixel
  task automatic frame();
    set_xy(0, 0);
    tick();
    set_xy(1, 1);
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    resn        = 1'b0;
    bus.x       = 7'd5;
    bus.y       = 8'd5;
    bus.mode    = 2'd0;
    bus.freeze  = 1'b0;
    tick();
    tick();
    check("rst_frame_start", 16'(bus.frame_start), 16'h0);
    check("rst_frame_cnt", 16'(bus.frame_cnt), 16'h0);
    resn = 1'b1;
    tick();

    // static checker
    set_xy(8, 0);
    check("static_8_0", bus.color, 16'h07E0);
    set_xy(8, 8);
    check("static_8_8", bus.color, 16'hF800);

    // frame detect, repeated origin gives one pulse
    set_xy(0, 0);
    check("fs_before", 16'(bus.frame_start), 16'h0);
    tick();
    check("fs_pulse", 16'(bus.frame_start), 16'h1);
    check("fcnt_1", 16'(bus.frame_cnt), 16'd1);
    tick();
    check("fs_hold1", 16'(bus.frame_start), 16'h0);
    tick();
    check("fs_hold2", 16'(bus.frame_start), 16'h0);
    check("fcnt_hold", 16'(bus.frame_cnt), 16'd1);

    // scrolling checker
    bus.mode = 2'd1;
    set_xy(1, 1);
    tick();
    frame();
    check("mode_q_scroll", 16'(dut.mode_q), 16'd1);
    for (int i = 0; i < 8; i++) frame();
    check("offset_2", 16'(dut.offset), 16'd2);
    check("div_0", 16'(dut.div), 16'd0);
    check("fcnt_10", 16'(bus.frame_cnt), 16'd10);
    set_xy(6, 6);
    check("scroll_6_6", bus.color, 16'hF800);
    set_xy(6, 1);
    check("scroll_6_1", bus.color, 16'h07E0);
    bus.freeze = 1'b1;
    for (int i = 0; i < 4; i++) frame();
    check("freeze_offset", 16'(dut.offset), 16'd2);
    check("freeze_div", 16'(dut.div), 16'd0);
    check("fcnt_14", 16'(bus.frame_cnt), 16'd14);
    bus.freeze = 1'b0;

    // mode change mid-frame waits for frame start
    bus.mode = 2'd2;
    set_xy(6, 6);
    check("mode_pending", bus.color, 16'hF800);
    tick();
    check("mode_pending_tick", bus.color, 16'hF800);
    frame();
    check("div_1", 16'(dut.div), 16'd1);
    set_xy(16, 6);
    check("bar_yellow", bus.color, 16'hFFE0);
    set_xy(64, 6);
    check("bar_magenta", bus.color, 16'hF81F);
    set_xy(126, 6);
    check("bar_black", bus.color, 16'h0000);

    // gradient
    bus.mode = 2'd3;
    frame();
    check("fcnt_16", 16'(bus.frame_cnt), 16'd16);
    set_xy(32, 16);
    check("grad_32_16", bus.color, 16'h4082);
    set_xy(8, 0);
`ifdef OLED_PATTERN_BORDER_EN
    check("grad_8_0", bus.color, 16'hFFFF);
`else
    check("grad_8_0", bus.color, 16'h1080);
`endif

    // asynchronous reset mid-frame
    resn = 1'b0;
    #1;
    check("arst_offset", 16'(dut.offset), 16'd0);
    check("arst_fcnt", 16'(bus.frame_cnt), 16'd0);
    check("arst_mode_q", 16'(dut.mode_q), 16'd0);
`ifdef OLED_PATTERN_BORDER_EN
    check("arst_color", bus.color, 16'hFFFF);
`else
    check("arst_color", bus.color, 16'h07E0);
`endif
    set_xy(0, 0);
    tick();
    resn = 1'b1;
    tick();
    check("post_rst_fs", 16'(bus.frame_start), 16'h1);
    check("post_rst_fcnt", 16'(bus.frame_cnt), 16'd1);
    set_xy(1, 1);
    tick();
    for (int i = 0; i < 7; i++) frame();
    check("fcnt_8", 16'(bus.frame_cnt), 16'd8);
    set_xy(126, 255);
    check("grad_126_255", bus.color, 16'hF85F);
    set_xy(0, 5);
`ifdef OLED_PATTERN_BORDER_EN
    check("border_x0", bus.color, 16'hFFFF);
`else
    check("grad_0_5", bus.color, 16'h0040);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/oled_pattern_gen.md
Name: oled_pattern_gen

Overview:
- Parametrised successor to the fixed checkerboard colour source that drives `oled_video`.
- Takes the pixel coordinate (x, y) requested by the OLED scan engine and returns an RGB565 colour in the same cycle.
- Offers four patterns: static checker, scrolling checker, 8 colour bars, and an RGB gradient.
- Tracks frame boundaries from the coordinate stream, applies mode changes only at frame start, and drives scroll animation from a frame divider.

Parameters:
- XW, 7, x coordinate width.
- YW, 8, y coordinate width.
- TILE_LOG2, 3, checker tile edge = 2^TILE_LOG2 pixels; legal 0..XW-1.
- COLOR_A, 16'h07E0, checker colour where tile parity = 1.
- COLOR_B, 16'hF800, checker colour where tile parity = 0.
- FRAME_DIV, 4, frames per scroll step; legal 1..255.

Ports:
- clk  in  1  pixel/system clock
- resn  in  1  asynchronous active-low reset
- x  in  XW  current pixel column from oled_video
- y  in  YW  current pixel row from oled_video
- mode  in  2  requested pattern (0 static, 1 scroll, 2 bars, 3 gradient)
- freeze  in  1  1 = hold scroll offset and divider
- color  out  16  RGB565 pixel colour, combinational from x, y and registered state
- frame_start  out  1  one-cycle pulse, registered
- frame_cnt  out  8  frames since reset, wraps 255->0

Behaviour:
Reset (resn low, asynchronous):
- mode_q=0, offset=0, div=0, frame_cnt=0, frame_start=0.
- x_q and y_q are set to all ones, so the first (0,0) after reset counts as a frame start.
- While in reset, color reflects mode 0 with offset 0.

Frame detect:
- fs = (x==0 && y==0) && !(x_q==0 && y_q==0).
- x_q and y_q register x and y every cycle.
- frame_start = fs delayed by one cycle (registered).
- A repeated (0,0) on consecutive cycles produces only one pulse.

On fs, in this clock edge:
- mode_q <= mode.
- frame_cnt increments.
- If mode_q==1 (the value before update) and !freeze:
  - if div==FRAME_DIV-1 then div <= 0 and offset <= offset+1;
  - else div <= div+1.
- Otherwise div and offset hold.
- offset is YW bits and wraps modulo 2^YW.

Changes outside fs:
- A mode change has no effect until the next fs.
- freeze changing mid-frame is sampled only at fs.

color per mode_q (combinational, zero latency, as oled_video requires):
- Mode 0: p = x[TILE_LOG2] ^ y[TILE_LOG2]; color = p ? COLOR_A : COLOR_B.
- Mode 1:
  - xs = (x + offset[XW-1:0]) mod 2^XW;
  - ys = (y + offset) mod 2^YW;
  - parity as mode 0 using xs and ys.
- Mode 2: bar = x[XW-1:XW-3].
  - Bars 0..7 are white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
- Mode 3: color = {x[XW-1:XW-5], frame_cnt[7:2], y[YW-1:YW-5]}.
  - The green field animates.
  - Requires XW>=5 and YW>=5.

Boundaries:
- Coordinates beyond panel size are still mapped by the same formulas; no clipping.
- Reset asserted mid-frame: all state clears immediately; the next (0,0) is a frame start.
- FRAME_DIV=1: offset advances every frame.

Optional Feature:
- Macro: OLED_PATTERN_BORDER_EN.
- When defined:
  - adds parameters H_RES (default 128) and V_RES (default 160);
  - color is forced to 16'hFFFF when x==0, x==H_RES-1, y==0 or y==V_RES-1, in every mode;
  - the border overrides all pattern logic.
- When undefined: no border logic and no H_RES/V_RES parameters; color is exactly the mode formula.

Test Plan:
1. Reset, then drive mode=0, x=8, y=0 -> color=16'h07E0; x=8, y=8 -> color=16'hF800.
2. After reset, present (0,0) once -> frame_start high exactly one cycle later, frame_cnt=1; hold (0,0) 3 cycles -> still only one pulse.
3. mode=1, FRAME_DIV=4, scan 8 full frames -> offset=2 at frame 9 start. At x=6, y=6 with offset=2: xs=ys=8, color=COLOR_B. With freeze=1 over the next 4 frames -> offset stays 2.
4. mode changed 0->2 mid-frame -> color unchanged until next fs, then x=16 gives yellow 16'hFFE0 and x=127 gives black 16'h0000.
5. mode=3, frame_cnt=8, x=127, y=255 -> color={5'h1F, 6'h02, 5'h1F}=16'hF85F.
6. Assert resn low mid-frame with offset=5, frame_cnt=20 -> immediately offset=0, frame_cnt=0, mode_q=0. With OLED_PATTERN_BORDER_EN defined, x=0 in any mode -> color=16'hFFFF.
